wash_cycle_sequencer: RTL and testbench
=======================================

Name: wash_cycle_sequencer

Overview:
Program sequencer directly upstream of the RON execution block. Steps a selected wash program through FILL, WASH, RINSE, SPIN and DONE phases. On each phase entry it issues one command (ctrl = phase code, data_out = phase duration in ticks) over a valid/ready handshake, then counts that phase down. Handles pause, door-open and cancel events.

Parameters:
TICK_DIV, 50_000_000, clk cycles per duration tick (set to 4 in simulation); must be >= 2
CNT_W, 8, width of the remaining-time counter and of data_out

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset; asynchronous assert, active-low
start  in  1  level; starts the selected program from IDLE
prog_sel  in  2  program select, latched on accepted start
door_closed  in  1  door switch, 1 = closed
pause  in  1  level; hold high to pause
cancel  in  1  abort to IDLE; highest priority
cmd_ready  in  1  downstream accepts the command
cmd_valid  out  1  command valid
ctrl  out  3  phase code to downstream
data_out  out  CNT_W  remaining ticks of the current phase
busy  out  1  program in progress (not IDLE, not DONE)
done  out  1  program complete
door_lock  out  1  door interlock request

Behaviour:
- Reset (rst = 0): all outputs 0; FSM returns to IDLE; counters and the prescaler clear. Applies mid-operation with no pending command kept.
- Phase codes: IDLE 0, FILL 1, WASH 2, RINSE 3, SPIN 4, DONE 5, PAUSE 6, PREWASH 7.
- Program table (FILL/WASH/RINSE/SPIN ticks):
  - prog 0: 4/20/10/8
  - prog 1: 2/8/4/4
  - prog 2: 6/40/16/12
  - prog 3: 0/0/0/10
- A phase with duration 0 is skipped entirely: no command is issued and it takes zero cycles.
- IDLE: start=1 with door_closed=1 latches prog_sel and enters the first phase with nonzero duration on the next cycle. start with the door open is ignored. While not in IDLE, start and prog_sel are ignored.
- Phase entry:
  - Load data_out with the phase duration, drive ctrl with the phase code, and assert cmd_valid the same cycle.
  - ctrl, data_out and cmd_valid hold stable until the cycle in which cmd_valid & cmd_ready; cmd_valid drops the next cycle.
  - Countdown and prescaler start only after the handshake. The prescaler is cleared on every handshake.
- Countdown:
  - The prescaler emits a 1-cycle tick every TICK_DIV cycles.
  - Each tick decrements data_out.
  - In the cycle data_out becomes 0, the FSM advances to the next nonzero phase, or to DONE after SPIN.
  - Phase latency is therefore 1 handshake + duration*TICK_DIV cycles.
- PAUSE:
  - Entered from any active phase when pause=1 or door_closed=0, including while a command is pending; a pending cmd_valid is withdrawn.
  - ctrl=6, cmd_valid=0, data_out frozen, prescaler held.
  - Exit when pause=0 and door_closed=1: re-enter the saved phase and re-issue its command with the frozen remaining value (not the full duration).
- DONE: ctrl=5, done=1, busy=0, door_lock=0. Returns to IDLE (done=0) when door_closed=0.
- cancel=1 in any non-IDLE state: next cycle IDLE, all outputs at reset values. Overrides a simultaneous tick, pause or handshake.
- busy=1 and door_lock=1 in all active phases and PAUSE.
- Simultaneous tick and pause: pause wins; the tick is not applied.
- data_out never wraps below 0.

Optional Feature:
PREWASH_EN:
- Defined: PREWASH (code 7, 6 ticks, all programs except prog 3) is inserted between FILL and WASH, with the same handshake and countdown rules.
- Undefined: code 7 is never emitted and the state is not synthesised.

Decomposition:
- Package wash_pkg holds:
  - phase enum (3-bit codes above)
  - program-select typedef
  - per-phase duration constants
  - a function returning the duration for a given (prog, phase)
- Sub-module tick_prescaler (parameter TICK_DIV; inputs clr and en; output tick) is natural.
- FSM, countdown and handshake stay in the top module.

Test Plan:
1. rst=0 mid-WASH → all outputs 0, ctrl=0, next handshake only after a fresh start.
2. TICK_DIV=4, prog 1, cmd_ready=1 → commands (1,2), (2,8), (3,4), (4,4) in order; done=1 with ctrl=5 after 18*4+4 handshake cycles.
3. prog 1 start, cmd_ready=0 for 10 cycles → cmd_valid=1, ctrl=1, data_out=2 stable throughout; countdown starts only after cmd_ready=1.
4. pause=1 in WASH at data_out=5 → ctrl=6, data_out stays 5; pause=0 → command (2,5) re-issued, 5*4 cycles to RINSE.
5. door_closed=0 in RINSE → PAUSE, door_lock=1; then cancel=1 → IDLE next cycle, door_lock=0, busy=0.
6. prog 3 start → first command (4,10), no FILL/WASH/RINSE commands. Start with door_closed=0 → no response.

Source files
------------

// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - phase codes, program durations and phase sequencing helpers
// Optional PREWASH_EN adds the PREWASH phase between FILL and WASH.
package wash_pkg;

  localparam int DUR_W = 8;

  typedef logic [1:0] prog_t;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4,
    PH_DONE  = 3'd5,
    PH_PAUSE = 3'd6
`ifdef PREWASH_EN
    , PH_PREWASH = 3'd7
`endif
  } phase_e;

  // Per-program durations in ticks, packed prog 3 .. prog 0.
  localparam logic [4*DUR_W-1:0] FILL_DUR  = {8'd0,  8'd6,  8'd2, 8'd4};
  localparam logic [4*DUR_W-1:0] WASH_DUR  = {8'd0,  8'd40, 8'd8, 8'd20};
  localparam logic [4*DUR_W-1:0] RINSE_DUR = {8'd0,  8'd16, 8'd4, 8'd10};
  localparam logic [4*DUR_W-1:0] SPIN_DUR  = {8'd10, 8'd12, 8'd4, 8'd8};
  localparam logic [DUR_W-1:0]   PREWASH_DUR = 8'd6;

  function automatic logic [DUR_W-1:0] phase_dur(prog_t prog, phase_e ph);
    logic [DUR_W-1:0] d;
    d = '0;
    case (ph)
      PH_FILL:  d = FILL_DUR[prog*DUR_W +: DUR_W];
      PH_WASH:  d = WASH_DUR[prog*DUR_W +: DUR_W];
      PH_RINSE: d = RINSE_DUR[prog*DUR_W +: DUR_W];
      PH_SPIN:  d = SPIN_DUR[prog*DUR_W +: DUR_W];
`ifdef PREWASH_EN
      PH_PREWASH: d = (prog == 2'd3) ? '0 : PREWASH_DUR;
`endif
      default:  d = '0;
    endcase
    return d;
  endfunction

  function automatic phase_e seq_next(phase_e ph);
    phase_e n;
    case (ph)
      PH_IDLE:    n = PH_FILL;
`ifdef PREWASH_EN
      PH_FILL:    n = PH_PREWASH;
      PH_PREWASH: n = PH_WASH;
`else
      PH_FILL:    n = PH_WASH;
`endif
      PH_WASH:    n = PH_RINSE;
      PH_RINSE:   n = PH_SPIN;
      default:    n = PH_DONE;
    endcase
    return n;
  endfunction

  // First phase after ph with a nonzero duration, or DONE.
  function automatic phase_e next_active(prog_t prog, phase_e ph);
    phase_e p;
    p = seq_next(ph);
    for (int i = 0; i < 5; i++) begin
      if (p != PH_DONE && phase_dur(prog, p) == '0) p = seq_next(p);
    end
    return p;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - emits a one-cycle tick every TICK_DIV enabled cycles
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  assign tick = en & (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/wash_cycle_sequencer.sv
// rtl/wash_cycle_sequencer.sv - wash program FSM with per-phase command handshake and countdown
// Optional PREWASH_EN inserts the PREWASH phase (see wash_pkg).
module wash_cycle_sequencer
  import wash_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       prog_sel,
  input  logic             door_closed,
  input  logic             pause,
  input  logic             cancel,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [2:0]       ctrl,
  output logic [CNT_W-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             door_lock
);

  phase_e           state_q, state_d;
  phase_e           saved_q, saved_d;
  prog_t            prog_q, prog_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             in_phase, hold_req, tick;
  phase_e           nxt;

  always_comb begin
    in_phase = 1'b0;
    case (state_q)
      PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: in_phase = 1'b1;
`ifdef PREWASH_EN
      PH_PREWASH: in_phase = 1'b1;
`endif
      default: in_phase = 1'b0;
    endcase
  end

  assign hold_req = pause | ~door_closed;

  // Prescaler runs only while counting down, and is frozen the cycle a pause is requested.
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  ((in_phase & valid_q & cmd_ready) | cancel),
    .en   (in_phase & ~valid_q & ~hold_req & ~cancel),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    prog_d  = prog_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    nxt     = PH_IDLE;
    if (cancel && state_q != PH_IDLE) begin
      state_d = PH_IDLE;
      saved_d = PH_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        PH_IDLE: begin
          if (start && door_closed) begin
            prog_d  = prog_sel;
            nxt     = next_active(prog_sel, PH_IDLE);
            state_d = nxt;
            if (nxt != PH_DONE) begin
              cnt_d   = CNT_W'(phase_dur(prog_sel, nxt));
              valid_d = 1'b1;
            end
          end
        end
        PH_DONE: begin
          if (!door_closed) state_d = PH_IDLE;
        end
        PH_PAUSE: begin
          if (!hold_req) begin
            state_d = saved_q;
            valid_d = 1'b1;
          end
        end
        default: begin
          if (hold_req) begin
            state_d = PH_PAUSE;
            saved_d = state_q;
            valid_d = 1'b0;
          end else if (valid_q) begin
            if (cmd_ready) valid_d = 1'b0;
          end else if (tick && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              nxt     = next_active(prog_q, state_q);
              state_d = nxt;
              if (nxt != PH_DONE) begin
                cnt_d   = CNT_W'(phase_dur(prog_q, nxt));
                valid_d = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PH_IDLE;
      saved_q <= PH_IDLE;
      prog_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      prog_q  <= prog_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign cmd_valid = valid_q;
  assign ctrl      = state_q;
  assign data_out  = cnt_q;
  assign busy      = in_phase | (state_q == PH_PAUSE);
  assign done      = (state_q == PH_DONE);
  assign door_lock = busy;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// tb/tb_wash_cycle_sequencer.sv - randomized self-checking bench against a command-list model
module tb_wash_cycle_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, door_closed, pause, cancel, cmd_ready;
  logic [1:0] prog_sel;
  logic       cmd_valid, busy, done, door_lock;
  logic [2:0] ctrl;
  logic [7:0] data_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int dur_tab [4][4] = '{'{4, 20, 10, 8}, '{2, 8, 4, 4}, '{6, 40, 16, 12}, '{0, 0, 0, 10}};

  wash_cycle_sequencer #(.TICK_DIV(TD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_sel(prog_sel),
    .door_closed(door_closed), .pause(pause), .cancel(cancel),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .ctrl(ctrl),
    .data_out(data_out), .busy(busy), .done(done), .door_lock(door_lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_phase(input string tag, input int code, input int val);
    bit hit;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      step();
      start = 1'b0;
      if (ctrl == 3'(code) && (val < 0 || data_out == 8'(val))) hit = 1;
    end
    check(tag, ctrl, code);
  endtask

  // Expected command list for a program, built from the duration table.
  task automatic run_prog(input int prog, input int pct);
    int exp_code[$];
    int exp_dur[$];
    int total, hs_cyc, hs_d, first_cyc, ec;
    bit pending, seen, fin;
    logic prev_valid, prev_ready;
    logic [2:0] prev_ctrl, last_ctrl;
    logic [7:0] prev_data;
    for (int p = 0; p < 4; p++) begin
      if (dur_tab[prog][p] > 0) begin
        exp_code.push_back(p + 1);
        exp_dur.push_back(dur_tab[prog][p]);
      end
`ifdef PREWASH_EN
      if (p == 0 && prog != 3) begin
        exp_code.push_back(7);
        exp_dur.push_back(6);
      end
`endif
    end
    total = 0;
    foreach (exp_dur[i]) total += 1 + TD * exp_dur[i];
    door_closed = 1'b1;
    prog_sel = 2'(prog);
    start = 1'b1;
    cmd_ready = ($urandom_range(99) < pct);
    prev_valid = 0; prev_ready = 0; prev_ctrl = 0; prev_data = 0; last_ctrl = 0;
    pending = 0; seen = 0; fin = 0; hs_cyc = 0; hs_d = 0; first_cyc = 0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      step();
      start = 1'b0;
      if (prev_valid && !prev_ready) begin
        check("stall_valid", cmd_valid, 1);
        check("stall_ctrl", ctrl, prev_ctrl);
        check("stall_data", data_out, prev_data);
      end
      if (pending && ctrl != last_ctrl) begin
        check("phase_len", cyc - hs_cyc, TD * hs_d + 1);
        pending = 0;
      end
      if (cmd_valid && !seen) begin
        seen = 1;
        first_cyc = cyc;
      end
      if (done) begin
        check("done_ctrl", ctrl, 5);
        check("done_busy", busy, 0);
        check("done_lock", door_lock, 0);
        check("cmds_left", exp_code.size(), 0);
        if (pct >= 100) check("total_len", cyc - first_cyc, total);
        fin = 1;
      end else begin
        check("active_busy", busy, 1);
        check("active_lock", door_lock, 1);
        cmd_ready = ($urandom_range(99) < pct);
        if (cmd_valid && cmd_ready) begin
          if (exp_code.size() == 0) begin
            check("extra_cmd_ctrl", ctrl, 0);
          end else begin
            ec = exp_code.pop_front();
            hs_d = exp_dur.pop_front();
            check("cmd_ctrl", ctrl, ec);
            check("cmd_data", data_out, hs_d);
            hs_cyc = cyc;
            pending = 1;
          end
        end
      end
      prev_valid = cmd_valid; prev_ready = cmd_ready;
      prev_ctrl = ctrl; prev_data = data_out; last_ctrl = ctrl;
    end
    if (!fin) check("timeout_done", done, 1);
    door_closed = 1'b0;
    step();
    check("door_idle_done", done, 0);
    check("door_idle_ctrl", ctrl, 0);
    door_closed = 1'b1;
  endtask

  initial begin
    int t, k;
    rst = 1'b0; start = 0; prog_sel = 0; door_closed = 1; pause = 0; cancel = 0; cmd_ready = 0;
    step(); step();
    check("rst_ctrl", ctrl, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_flags", {busy, done, door_lock}, 0);
    rst = 1'b1;
    step();

    // Reset asserted mid-WASH.
    cmd_ready = 1; prog_sel = 0; start = 1;
    wait_phase("reach_wash", 2, -1);
    rst = 1'b0;
    #1;
    check("mrst_ctrl", ctrl, 0);
    check("mrst_valid", cmd_valid, 0);
    check("mrst_data", data_out, 0);
    check("mrst_flags", {busy, done, door_lock}, 0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_idle", {cmd_valid, ctrl}, 0);
    end

    // Back-pressure holds the first command stable.
    cmd_ready = 0; prog_sel = 1; start = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      start = 0;
      check("bp_cmd", {cmd_valid, ctrl, data_out}, {1'b1, 3'd1, 8'd2});
    end
    cmd_ready = 1;
    t = cyc;
    while (cyc < t + TD) step();
    check("bp_hold_data", data_out, 2);
    step();
    check("bp_first_tick", data_out, 1);
    cancel = 1;
    step();
    check("bp_cancel", {ctrl, busy}, 0);
    cancel = 0;

    // Pause in WASH, resume with frozen count, then door open and cancel.
    cmd_ready = 1; prog_sel = 1; start = 1;
    wait_phase("reach_wash5", 2, 5);
    pause = 1;
    step();
    check("pause_ctrl", ctrl, 6);
    check("pause_valid", cmd_valid, 0);
    check("pause_busy", {busy, door_lock}, 3);
    k = $urandom_range(3, 8);
    for (int i = 0; i < k; i++) begin
      step();
      check("pause_frozen", {ctrl, data_out}, {3'd6, 8'd5});
    end
    pause = 0;
    step();
    check("resume_cmd", {cmd_valid, ctrl, data_out}, {1'b1, 3'd2, 8'd5});
    t = cyc;
    wait_phase("reach_rinse", 3, -1);
    check("resume_len", cyc - t, 5 * TD + 1);
    door_closed = 0;
    step();
    check("door_pause", {ctrl, cmd_valid, busy, door_lock}, {3'd6, 1'b0, 1'b1, 1'b1});
    cancel = 1;
    step();
    check("cancel_out", {ctrl, cmd_valid, data_out, busy, done, door_lock}, 0);
    cancel = 0; door_closed = 1;
    step();

    // Start with the door open is ignored.
    door_closed = 0; prog_sel = 3; start = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("door_open_start", {ctrl, cmd_valid, busy}, 0);
    end
    start = 0; door_closed = 1;
    step();

    run_prog(3, 100);
    run_prog(1, 100);
    for (int r = 0; r < 6; r++) run_prog($urandom_range(3), $urandom_range(40, 100));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
